// File: rtl/fifo_reader.sv
// Read-side controller: pops a synchronous FIFO and streams its words through a 3-entry elastic buffer.
// Latency: read enable in cycle N, FIFO word in N+1, out_valid in N+2; 1 word/cycle sustained.
// Backpressure: out_ready stalls the buffer only; reads are throttled from registered occupancy, never from out_ready.
// Optional delivered-word counter (word_count port) is built when FIFO_READER_COUNT_EN is defined.
module fifo_reader #(
  parameter int tamano_datos = 10,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic                    fifo_error,
  input  logic [tamano_datos-1:0] fifo_data_out,
  output logic                    fifo_read_enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [tamano_datos-1:0] out_data,
  output logic                    fault,
  output logic [1:0]              state
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]    word_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  // Reject nonsensical widths at elaboration time.
  if (tamano_datos < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("fifo_reader: tamano_datos and CNT_WIDTH must be positive");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_occ;
  logic [1:0]              w_occ_nxt;
  logic                    r_inflight;
  logic [1:0]              r_wr_ptr;
  logic [1:0]              r_rd_ptr;
  logic [tamano_datos-1:0] r_buf [0:2];
  logic [tamano_datos-1:0] r_last;
  logic [2:0]              w_level;
  logic                    w_rd_en;
  logic                    w_cap;
  logic                    w_pop;

  // Circular pointer over the three buffer slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already committed to the buffer: stored plus the one arriving from the FIFO.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};

  // Reads depend only on registered occupancy, so out_ready never reaches the FIFO
  // combinationally; reset gating keeps the FIFO untouched while held in reset.
  assign w_rd_en = reset & (r_state != ST_FAULT) & ~fifo_empty & (w_level < 3'd3);
  assign w_cap   = r_inflight;
  assign w_pop   = out_valid & out_ready;

  assign fifo_read_enable = w_rd_en;
  assign out_valid        = (r_occ != 2'd0);
  // With the buffer empty the read pointer already points past the last word,
  // so the last delivered word is kept separately to hold out_data steady.
  assign out_data         = (r_occ != 2'd0) ? r_buf[r_rd_ptr] : r_last;
  assign fault            = (r_state == ST_FAULT);
  assign state            = r_state;

  // Occupancy after this edge: capture adds, pop removes, both together cancel.
  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_cap, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Next-state logic; a FIFO error overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (fifo_error) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_en) w_state_nxt = ST_STREAM;
        end
        ST_STREAM: begin
          if (w_occ_nxt == 2'd3)                  w_state_nxt = ST_HOLD;
          else if (w_occ_nxt == 2'd0 && !w_rd_en) w_state_nxt = ST_IDLE;
        end
        ST_HOLD: begin
          if (w_pop) w_state_nxt = ST_STREAM;
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Elastic buffer: capture the FIFO word a cycle after the read, pop on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_last     <= '0;
      for (int i = 0; i < 3; i++) r_buf[i] <= '0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= w_rd_en;
      if (w_cap) begin
        r_buf[r_wr_ptr] <= fifo_data_out;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_last   <= r_buf[r_rd_ptr];
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

`ifdef FIFO_READER_COUNT_EN
  logic [CNT_WIDTH-1:0] r_word_count;

  // Delivered-word counter; keeps counting while draining in FAULT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_word_count <= '0;
    else if (w_pop) r_word_count <= r_word_count + 1'b1;
  end

  assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural FIFO plus a queue-based reference of words in transit.
// Latency: checks every cycle at the falling edge against the reference.
// Backpressure: out_ready driven from tables, alternating patterns and $urandom.
module tb_fifo_reader;
  localparam int W  = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic          fifo_error;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_read_enable;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          fault;
  logic [1:0]    state;
`ifdef FIFO_READER_COUNT_EN
  logic [CW-1:0] word_count;
`endif

  fifo_reader #(.tamano_datos(W), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_error       (fifo_error),
    .fifo_data_out    (fifo_data_out),
    .fifo_read_enable (fifo_read_enable),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .fault            (fault),
    .state            (state)
`ifdef FIFO_READER_COUNT_EN
    ,
    .word_count       (word_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: FIFO contents, words read but not yet delivered, and sticky flags.
  logic [W-1:0]  q_fifo [$];
  logic [W-1:0]  exp_q  [$];
  logic          last_rd;
  logic          m_fault;
  logic [W-1:0]  m_last;
  logic [CW-1:0] m_cnt;
  logic          prev_hold;
  logic [W-1:0]  prev_dat;
  int            n_rd;
  int            n_del;

  logic          s_rd;
  logic          s_vld;
  logic [W-1:0]  s_dat;
  logic [1:0]    s_st;

  int total = 0;
  int bad   = 0;
  int base, d0, gaps, k, pushed;

  typedef struct {
    logic         rdy;
    logic         rd;
    logic         vld;
    logic [W-1:0] dat;
    logic [1:0]   st;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic int avail_f();
    return exp_q.size() - int'(last_rd);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_rd   = 1'b0;
    m_fault   = 1'b0;
    m_last    = '0;
    m_cnt     = '0;
    prev_hold = 1'b0;
  endtask

  // One clock cycle: compare at the falling edge, then advance FIFO and reference.
  task automatic tick();
    int           avail;
    logic [1:0]   exp_st;
    logic [W-1:0] exp_dat;
    logic         hs;
    logic         pushed_now;
    @(negedge clk);
    s_rd  = fifo_read_enable;
    s_vld = out_valid;
    s_dat = out_data;
    s_st  = state;
    avail = avail_f();
    if (m_fault)                        exp_st = 2'd3;
    else if (avail == 3)                exp_st = 2'd2;
    else if (avail == 0 && !last_rd)    exp_st = 2'd0;
    else                                exp_st = 2'd1;
    exp_dat = (avail > 0) ? exp_q[0] : m_last;
    chk("rd_en",     {31'd0, s_rd},  {31'd0, (!m_fault && !fifo_empty && exp_q.size() < 3)});
    chk("out_valid", {31'd0, s_vld}, {31'd0, (avail > 0)});
    chk("out_data",  {22'd0, s_dat}, {22'd0, exp_dat});
    chk("state",     {30'd0, s_st},  {30'd0, exp_st});
    chk("fault",     {31'd0, fault}, {31'd0, m_fault});
    if (prev_hold) chk("hold_stable", {22'd0, s_dat}, {22'd0, prev_dat});
`ifdef FIFO_READER_COUNT_EN
    chk("word_count", {16'd0, word_count}, {16'd0, m_cnt});
`endif
    hs        = s_vld & out_ready;
    prev_hold = s_vld & ~out_ready;
    prev_dat  = s_dat;
    @(posedge clk);
    if (hs) begin
      n_del++;
      m_cnt = m_cnt + 1'b1;
      if (exp_q.size() > 0) m_last = exp_q.pop_front();
    end
    m_fault = m_fault | fifo_error;
    if (s_rd) n_rd++;
    #1;
    pushed_now = 1'b0;
    if (s_rd && q_fifo.size() > 0) begin
      fifo_data_out = q_fifo.pop_front();
      exp_q.push_back(fifo_data_out);
      pushed_now = 1'b1;
    end else begin
      fifo_data_out = W'($urandom);
    end
    last_rd    = pushed_now;
    fifo_empty = (q_fifo.size() == 0);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid},        32'd0);
    chk("rst_rd_en", {31'd0, fifo_read_enable}, 32'd0);
    chk("rst_state", {30'd0, state},            32'd0);
    chk("rst_fault", {31'd0, fault},            32'd0);
    chk("rst_data",  {22'd0, out_data},         32'd0);
`ifdef FIFO_READER_COUNT_EN
    chk("rst_count", {16'd0, word_count},       32'd0);
`endif
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic push_words(input int n, input logic [W-1:0] first);
    for (int i = 0; i < n; i++) q_fifo.push_back(first + W'(i));
    fifo_empty = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "bench timeout");
  end

  initial begin
    // 5-word stream with the consumer always ready, cycle by cycle.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 10'h000, 2'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 10'h000, 2'd1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 10'h001, 2'd1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 10'h002, 2'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 10'h003, 2'd1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 10'h004, 2'd1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 10'h005, 2'd1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 10'h005, 2'd0};

    reset         = 1'b0;
    fifo_empty    = 1'b1;
    fifo_error    = 1'b0;
    fifo_data_out = '0;
    out_ready     = 1'b0;
    n_rd          = 0;
    n_del         = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Empty FIFO: nothing happens.
    repeat (10) tick();

    // Table-driven 5-word stream.
    push_words(5, 10'h001);
    for (int i = 0; i < 8; i++) begin
      out_ready = tbl[i].rdy;
      tick();
      chk("tbl_rd",    {31'd0, s_rd},  {31'd0, tbl[i].rd});
      chk("tbl_valid", {31'd0, s_vld}, {31'd0, tbl[i].vld});
      chk("tbl_data",  {22'd0, s_dat}, {22'd0, tbl[i].dat});
      chk("tbl_state", {30'd0, s_st},  {30'd0, tbl[i].st});
    end
`ifdef FIFO_READER_COUNT_EN
    chk("count_after_5", {16'd0, word_count}, 32'd5);
`endif

    // Stalled consumer: exactly three reads, HOLD, head stable; then full-rate drain.
    base = n_rd;
    push_words(8, 10'h100);
    out_ready = 1'b0;
    repeat (6) tick();
    chk("hold_reads", n_rd - base, 32'd3);
    chk("hold_state", {30'd0, s_st},  32'd2);
    chk("hold_data",  {22'd0, s_dat}, 32'h100);
    out_ready = 1'b1;
    gaps = 0;
    d0   = n_del;
    repeat (8) begin
      tick();
      if (!s_vld) gaps++;
    end
    chk("hold_gaps",      gaps,        32'd0);
    chk("hold_delivered", n_del - d0,  32'd8);
    repeat (3) tick();

    // Alternating ready over 6 words.
    push_words(6, 10'h200);
    d0 = n_del;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c % 2 == 0);
      tick();
    end
    chk("alt_delivered", n_del - d0, 32'd6);

    // Random pushes and random consumer readiness.
    d0     = n_del;
    pushed = 0;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 2) == 0 && q_fifo.size() < 8) begin
        q_fifo.push_back(W'($urandom));
        fifo_empty = 1'b0;
        pushed++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    k = 0;
    while ((q_fifo.size() > 0 || exp_q.size() > 0) && k < 60) begin
      tick();
      k++;
    end
    chk("rand_left",  q_fifo.size() + exp_q.size(), 32'd0);
    chk("rand_count", n_del - d0, pushed);

    // Error with two words buffered and one in flight: all drain, no more reads.
    push_words(4, 10'h300);
    out_ready = 1'b0;
    k = 0;
    while (avail_f() != 2 && k < 10) begin
      tick();
      k++;
    end
    chk("fault_setup", avail_f(), 32'd2);
    fifo_error = 1'b1;
    tick();
    fifo_error = 1'b0;
    base = n_rd;
    repeat (4) tick();
    chk("fault_no_reads", n_rd - base, 32'd0);
    out_ready = 1'b1;
    d0 = n_del;
    repeat (6) tick();
    chk("fault_drained", n_del - d0,      32'd3);
    chk("fault_sticky",  {31'd0, fault},  32'd1);
    chk("fault_state",   {30'd0, state},  32'd3);
    do_reset();

    // Reset mid-stream with two words buffered.
    push_words(5, 10'h3c0);
    out_ready = 1'b0;
    k = 0;
    while (avail_f() != 2 && k < 10) begin
      tick();
      k++;
    end
    chk("midrst_setup", {31'd0, out_valid}, 32'd1);
    do_reset();
    out_ready = 1'b1;
    k = 0;
    while ((q_fifo.size() > 0 || exp_q.size() > 0) && k < 40) begin
      tick();
      k++;
    end
    chk("midrst_left", q_fifo.size() + exp_q.size(), 32'd0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
